// File: rtl/io_pwm_led.sv
// Multi-channel PWM LED driver behind a CPU request/acknowledge IO port.
// Duties are written into shadow registers and copied to the active set at each period boundary.

`ifndef DIRECTION_WRITE
`define DIRECTION_WRITE 1'b1
`endif

module io_pwm_led #(
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned DUTY_BITS = 5,
  parameter int unsigned PRESCALE  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                io_req,
  input  logic                io_dir,
  input  logic [7:0]          io_wdata,
  output logic                io_ack,
  output logic [7:0]          io_rdata,
  output logic [CHANNELS-1:0] pwm
);

  localparam int unsigned    PsW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax   = PsW'(PRESCALE - 1);
  localparam logic [3:0]     ChanLim = 4'(CHANNELS);
  localparam logic [2:0]     RdLast  = 3'(CHANNELS - 1);

  logic                 io_ack_q, io_ack_d;
  logic [7:0]           io_rdata_q, io_rdata_d;
  logic [CHANNELS-1:0]  pwm_q, pwm_d;
  logic [2:0]           rd_ptr_q, rd_ptr_d;
  logic [PsW-1:0]       ps_q, ps_d;
  logic [DUTY_BITS-1:0] cnt_q, cnt_d;
  logic [DUTY_BITS-1:0] shadow_q [CHANNELS];
  logic [DUTY_BITS-1:0] shadow_d [CHANNELS];
  logic [DUTY_BITS-1:0] active_q [CHANNELS];
  logic [DUTY_BITS-1:0] active_d [CHANNELS];

  logic                 accept;
  logic                 is_write;
  logic                 wr_valid;
  logic [2:0]           wr_ch;
  logic [DUTY_BITS-1:0] wr_duty;
  logic                 ps_wrap;
  logic                 boundary;
  logic [DUTY_BITS-1:0] rd_duty;

  // A request is taken only outside the ack cycle, so a held io_req cannot act twice back to back.
  always_comb begin
    accept   = io_req & ~io_ack_q;
    is_write = (io_dir == `DIRECTION_WRITE);
    wr_ch    = io_wdata[7:5];
    wr_duty  = io_wdata[DUTY_BITS-1:0];
    wr_valid = accept & is_write & ({1'b0, wr_ch} < ChanLim);
  end

  // Timebase: prescaler feeds the PWM counter; a boundary is the counter wrap back to zero.
  always_comb begin
    ps_wrap  = (ps_q == PsMax);
    ps_d     = ps_wrap ? '0 : ps_q + 1'b1;
    cnt_d    = cnt_q + DUTY_BITS'(ps_wrap);
    boundary = ps_wrap & (&cnt_q);
  end

  // Active takes the pre-write shadow, so a write landing on a boundary applies one period later.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (wr_valid && (wr_ch == 3'(i))) begin
        shadow_d[i] = wr_duty;
      end
      if (boundary) begin
        active_d[i] = shadow_q[i];
      end
    end
  end

  always_comb begin
    rd_duty = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (rd_ptr_q == 3'(i)) begin
        rd_duty = active_q[i];
      end
    end
  end

  always_comb begin
    io_ack_d   = accept;
    io_rdata_d = io_rdata_q;
    rd_ptr_d   = rd_ptr_q;
    if (accept && !is_write) begin
      io_rdata_d = {rd_ptr_q, 5'(rd_duty)};
      rd_ptr_d   = (rd_ptr_q == RdLast) ? 3'd0 : rd_ptr_q + 3'd1;
    end
  end

  // Compare against next-state values so pwm lines up with the counter it reflects.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      pwm_d[i] = (&active_d[i]) | (cnt_d < active_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_ack_q   <= 1'b0;
      io_rdata_q <= '0;
      pwm_q      <= '0;
      rd_ptr_q   <= '0;
      ps_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      io_ack_q   <= io_ack_d;
      io_rdata_q <= io_rdata_d;
      pwm_q      <= pwm_d;
      rd_ptr_q   <= rd_ptr_d;
      ps_q       <= ps_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign io_ack   = io_ack_q;
  assign io_rdata = io_rdata_q;
  assign pwm      = pwm_q;

endmodule
